// File: rtl/auto_play_pkg.sv
// Shared types, default frame timings and helpers for the attract/soak-test auto player.
package auto_play_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DELAY     = 4'd1,
        ST_COIN      = 4'd2,
        ST_GAP1      = 4'd3,
        ST_START     = 4'd4,
        ST_GAP2      = 4'd5,
        ST_THROW_ON  = 4'd6,
        ST_THROW_OFF = 4'd7,
        ST_DONE      = 4'd8
    } state_e;

    typedef struct packed {
        logic coin_n;
        logic start_n;
        logic throw_n;
        logic busy;
        logic done;
    } drive_t;

    localparam drive_t DRIVE_IDLE = '{coin_n: 1'b1, start_n: 1'b1, throw_n: 1'b1,
                                      busy: 1'b0, done: 1'b0};

    localparam int DEF_CNT_W        = 8;
    localparam int DEF_DELAY_FR     = 120;
    localparam int DEF_COIN_FR      = 4;
    localparam int DEF_GAP_FR       = 30;
    localparam int DEF_START_FR     = 4;
    localparam int DEF_THROW_ON_FR  = 3;
    localparam int DEF_THROW_OFF_FR = 20;
    localparam int DEF_NUM_THROWS   = 16;

    // Width of the throws counter: enough to hold NUM_THROWS, never narrower than one bit.
    function automatic int throws_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit frames_ok(input int fr, input int cnt_w);
        return (fr >= 1) && (fr < (1 << cnt_w));
    endfunction

    function automatic logic is_timed(input state_e s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter: expires on a tick that arrives while the count is already zero.
module frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_tick,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = i_tick && (r_count == '0);

endmodule

// File: rtl/auto_play_sequencer.sv
// Frame-timed auto player: wait, coin, start, then periodic throws, aborting on enable drop or player input.
module auto_play_sequencer
    import auto_play_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DELAY_FR     = DEF_DELAY_FR,
    parameter int COIN_FR      = DEF_COIN_FR,
    parameter int GAP_FR       = DEF_GAP_FR,
    parameter int START_FR     = DEF_START_FR,
    parameter int THROW_ON_FR  = DEF_THROW_ON_FR,
    parameter int THROW_OFF_FR = DEF_THROW_OFF_FR,
    parameter int NUM_THROWS   = DEF_NUM_THROWS
) (
    input  logic clk_pix,
    input  logic reset_n,
    input  logic enable,
    input  logic frame_tick,
    input  logic player_active,
    output logic auto_coin_n,
    output logic auto_start_n,
    output logic auto_throw_n,
    output logic busy,
    output logic done
);

    localparam int TW = throws_width(NUM_THROWS);

    if (!frames_ok(DELAY_FR, CNT_W) || !frames_ok(COIN_FR, CNT_W) ||
        !frames_ok(GAP_FR, CNT_W) || !frames_ok(START_FR, CNT_W) ||
        !frames_ok(THROW_ON_FR, CNT_W) || !frames_ok(THROW_OFF_FR, CNT_W) ||
        (NUM_THROWS < 0)) begin : g_bad_params
        $error("auto_play_sequencer: frame counts must lie in [1, 2**CNT_W-1], NUM_THROWS >= 0");
    end

    state_e           r_state;
    state_e           w_state_next;
    drive_t           r_drive;
    drive_t           w_drive_next;
    logic [TW-1:0]    r_throws;
    logic [TW-1:0]    w_throws_inc;
    logic             w_tick;
    logic             w_expired;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_last_throw;

    function automatic logic [CNT_W-1:0] phase_len(input state_e s);
        logic [CNT_W-1:0] len;
        case (s)
            ST_DELAY:     len = CNT_W'(DELAY_FR - 1);
            ST_COIN:      len = CNT_W'(COIN_FR - 1);
            ST_GAP1:      len = CNT_W'(GAP_FR - 1);
            ST_START:     len = CNT_W'(START_FR - 1);
            ST_GAP2:      len = CNT_W'(GAP_FR - 1);
            ST_THROW_ON:  len = CNT_W'(THROW_ON_FR - 1);
            ST_THROW_OFF: len = CNT_W'(THROW_OFF_FR - 1);
            default:      len = '0;
        endcase
        return len;
    endfunction

    // Ticks only count in timed states; the tick that causes a transition is consumed by the old state.
    assign w_tick       = frame_tick && is_timed(r_state);
    assign w_load       = (w_state_next != r_state);
    assign w_load_val   = phase_len(w_state_next);
    assign w_throws_inc = r_throws + 1'b1;
    assign w_last_throw = (NUM_THROWS != 0) && (w_throws_inc == TW'(NUM_THROWS));

    frame_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .i_clk      (clk_pix),
        .i_rst_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_tick     (w_tick),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_drive  <= DRIVE_IDLE;
            r_throws <= '0;
        end else begin
            r_state <= w_state_next;
            r_drive <= w_drive_next;
            if (w_state_next == ST_IDLE) begin
                r_throws <= '0;
            end else if ((NUM_THROWS != 0) && (r_state == ST_THROW_ON) &&
                         (w_state_next != ST_THROW_ON)) begin
                r_throws <= w_throws_inc;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else if (player_active && is_timed(r_state)) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      if (!player_active) w_state_next = ST_DELAY;
                ST_DELAY:     if (w_expired) w_state_next = ST_COIN;
                ST_COIN:      if (w_expired) w_state_next = ST_GAP1;
                ST_GAP1:      if (w_expired) w_state_next = ST_START;
                ST_START:     if (w_expired) w_state_next = ST_GAP2;
                ST_GAP2:      if (w_expired) w_state_next = ST_THROW_ON;
                ST_THROW_ON: begin
                    if (w_expired) begin
                        w_state_next = w_last_throw ? ST_DONE : ST_THROW_OFF;
                    end
                end
                ST_THROW_OFF: if (w_expired) w_state_next = ST_THROW_ON;
                ST_DONE:      w_state_next = ST_DONE;
                default:      w_state_next = ST_IDLE;
            endcase
        end
    end

    // Decoding the next state lets the registered outputs move on the same edge as the state.
    always_comb begin
        w_drive_next      = DRIVE_IDLE;
        w_drive_next.busy = is_timed(w_state_next);
        case (w_state_next)
            ST_COIN:     w_drive_next.coin_n  = 1'b0;
            ST_START:    w_drive_next.start_n = 1'b0;
            ST_THROW_ON: w_drive_next.throw_n = 1'b0;
            ST_DONE:     w_drive_next.done    = 1'b1;
            default:     ;
        endcase
    end

    assign auto_coin_n  = r_drive.coin_n;
    assign auto_start_n = r_drive.start_n;
    assign auto_throw_n = r_drive.throw_n;
    assign busy         = r_drive.busy;
    assign done         = r_drive.done;

endmodule

// File: tb/tb_auto_play_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor pops one per observed change.
module tb_auto_play_sequencer;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic reset_n, enable, enable2, frame_tick, player_active;
    logic coin_n, start_n, throw_n, busy, done;
    logic coin2, start2, throw2, busy2, done2;
    logic [4:0] vec;
    assign vec = {coin_n, start_n, throw_n, busy, done};

    auto_play_sequencer #(
        .CNT_W(8), .DELAY_FR(2), .COIN_FR(1), .GAP_FR(1), .START_FR(1),
        .THROW_ON_FR(1), .THROW_OFF_FR(1), .NUM_THROWS(2)
    ) dut (
        .clk_pix(clk_pix), .reset_n(reset_n), .enable(enable), .frame_tick(frame_tick),
        .player_active(player_active), .auto_coin_n(coin_n), .auto_start_n(start_n),
        .auto_throw_n(throw_n), .busy(busy), .done(done)
    );

    auto_play_sequencer #(
        .CNT_W(8), .DELAY_FR(2), .COIN_FR(1), .GAP_FR(1), .START_FR(1),
        .THROW_ON_FR(1), .THROW_OFF_FR(1), .NUM_THROWS(0)
    ) dut_loop (
        .clk_pix(clk_pix), .reset_n(reset_n), .enable(enable2), .frame_tick(frame_tick),
        .player_active(player_active), .auto_coin_n(coin2), .auto_start_n(start2),
        .auto_throw_n(throw2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [4:0] v;
        int         tk;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_applied = 0;
    int   n_miss    = 0;
    int   sent      = 0;
    int   tick_no   = 0;
    bit   mon_go    = 1'b0;
    int   pulses2 = 0, bad_per2 = 0, done2_seen = 0, first_fall2 = -1, last_fall2 = -1;

    task automatic push(input logic [4:0] v, input int tk, input string tag);
        exp_t e;
        e.v = v; e.tk = tk; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic [4:0] want);
        n_applied++;
        if (vec !== want) begin
            n_miss++;
            $display("FAIL %s: outputs %b, required %b", tag, vec, want);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_applied++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_pix);
        #1;
    endtask

    // n frames: each is a one-clock tick followed by nine quiet clocks.
    task automatic tick_run(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(posedge clk_pix); #1;
            frame_tick = 1'b0;
            sent++;
            idle(9);
        end
    endtask

    task automatic burst(input int n);
        frame_tick = 1'b1;
        repeat (n) @(posedge clk_pix);
        #1;
        frame_tick = 1'b0;
        sent += n;
        idle(9);
    endtask

    // Monitor: compare each observed change, then count a tick that the next edge will consume.
    initial begin
        logic [4:0] prev;
        logic       prev_t2;
        exp_t       e;
        wait (mon_go);
        prev    = vec;
        prev_t2 = throw2;
        forever begin
            @(negedge clk_pix);
            if (vec !== prev) begin
                n_applied++;
                if (sb_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_change: outputs %b at tick %0d, required no change",
                             vec, tick_no);
                end else begin
                    e = sb_q.pop_front();
                    if ((vec !== e.v) || (tick_no != e.tk)) begin
                        n_miss++;
                        $display("FAIL %s: outputs %b at tick %0d, required %b at tick %0d",
                                 e.tag, vec, tick_no, e.v, e.tk);
                    end else begin
                        $display("vector %s: %b at tick %0d", e.tag, vec, tick_no);
                    end
                end
                prev = vec;
            end
            if (prev_t2 && !throw2) begin
                pulses2++;
                if (first_fall2 < 0) first_fall2 = tick_no;
                if ((last_fall2 >= 0) && (tick_no - last_fall2 != 2)) bad_per2++;
                last_fall2 = tick_no;
            end
            prev_t2 = throw2;
            if (done2) done2_seen++;
            if (frame_tick) tick_no++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; enable2 = 1'b0; frame_tick = 1'b0; player_active = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(2);
        check_now("reset_state", 5'b11100);
        mon_go = 1'b1;
        idle(2);

        // Full run to DONE with two throws.
        push(5'b11110, 0, "arm");        push(5'b01110, 2, "coin_low");
        push(5'b11110, 3, "gap1");       push(5'b10110, 4, "start_low");
        push(5'b11110, 5, "gap2");       push(5'b11010, 6, "throw1_low");
        push(5'b11110, 7, "throw1_off"); push(5'b11010, 8, "throw2_low");
        push(5'b11101, 9, "done");
        enable = 1'b1;
        idle(3);
        tick_run(9);
        tick_run(3);
        check_now("done_holds", 5'b11101);

        // Abort mid-START by player input, then re-arm with the full delay.
        push(5'b11100, 12, "disable_from_done");
        enable = 1'b0; idle(2);
        push(5'b11110, 12, "rearm");
        enable = 1'b1; idle(2);
        push(5'b01110, 14, "coin_low_b"); push(5'b11110, 15, "gap1_b");
        push(5'b10110, 16, "start_low_b");
        tick_run(4);
        check_now("in_start", 5'b10110);
        push(5'b11100, 16, "player_abort");
        player_active = 1'b1;
        @(posedge clk_pix); #1;
        check_now("abort_same_edge", 5'b11100);
        idle(2);
        push(5'b11110, 16, "player_release");
        player_active = 1'b0; idle(2);
        push(5'b01110, 18, "coin_low_c");   push(5'b11110, 19, "gap1_c");
        push(5'b10110, 20, "start_low_c");  push(5'b11110, 21, "gap2_c");
        push(5'b11010, 22, "throw1_low_c"); push(5'b11110, 23, "throw1_off_c");
        push(5'b11010, 24, "throw2_low_c");
        tick_run(8);

        // Enable drop in the second throw must clear the throw count.
        push(5'b11100, 24, "disable_in_throw");
        enable = 1'b0;
        @(posedge clk_pix); #1;
        check_now("throw_released", 5'b11100);
        idle(2);
        push(5'b11110, 24, "rearm_d");
        enable = 1'b1; idle(2);
        push(5'b01110, 26, "coin_low_d");   push(5'b11110, 27, "coin_b2b_d");
        push(5'b10110, 28, "start_low_d");  push(5'b11110, 29, "gap2_d");
        push(5'b11010, 30, "throw1_low_d"); push(5'b11110, 31, "throw1_off_d");
        push(5'b11010, 32, "throw2_low_d"); push(5'b11101, 33, "done_d");
        tick_run(1);
        burst(2);
        tick_run(6);
        check_now("done_after_rearm", 5'b11101);

        // Async reset mid-COIN.
        push(5'b11100, 33, "disable_e"); enable = 1'b0; idle(2);
        push(5'b11110, 33, "rearm_e");   enable = 1'b1; idle(2);
        push(5'b01110, 35, "coin_low_e");
        tick_run(2);
        #2;
        push(5'b11100, 35, "async_reset");
        reset_n = 1'b0;
        #1;
        check_now("reset_immediate", 5'b11100);
        enable = 1'b0;
        @(posedge clk_pix); #1;
        idle(2);
        reset_n = 1'b1;
        tick_run(3);
        push(5'b11110, 38, "arm_after_reset");
        enable = 1'b1; idle(3);
        push(5'b11100, 38, "disable_f");
        enable = 1'b0; idle(2);

        // Unlimited throws on the second instance.
        enable2 = 1'b1;
        idle(2);
        tick_run(1000);
        check_int("loop_first_throw_tick", first_fall2, 44);
        check_int("loop_pulse_count", pulses2, 498);
        check_int("loop_bad_periods", bad_per2, 0);
        check_int("loop_done_cycles", done2_seen, 0);
        check_int("loop_busy", int'(busy2), 1);
        check_int("loop_coin_start_idle", int'({coin2, start2}), 3);

        for (int i = 0; (i < 50) && (sb_q.size() != 0); i++) @(posedge clk_pix);
        check_int("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
